// File: rtl/ddr4_cmd_issuer.sv
// DDR4 command issuer: accepts one read/write request at a time, tracks the open row of
// every bank and emits PRE/ACT/RD/WR on a registered command bus with tRP, tRCD, tRAS
// and tCCD spacing. Open-page policy; data movement is handled elsewhere.
module ddr4_cmd_issuer #(
  parameter int unsigned BGWIDTH   = 2,
  parameter int unsigned BAWIDTH   = 2,
  parameter int unsigned ADDRWIDTH = 17,
  parameter int unsigned COLWIDTH  = 10,
  parameter int unsigned TRCD      = 4,
  parameter int unsigned TRP       = 4,
  parameter int unsigned TRAS      = 16,
  parameter int unsigned TCCD      = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 cke,
  output logic                 cs_n,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic                 done,
  output logic                 done_hit
);

  localparam int unsigned BANKW  = BGWIDTH + BAWIDTH;
  localparam int unsigned NBANKS = 1 << BANKW;

  localparam logic [5:0] TRP_LD  = 6'(TRP - 1);
  localparam logic [5:0] TRCD_LD = 6'(TRCD - 1);
  localparam logic [5:0] TRAS_LD = 6'(TRAS - 1);
  localparam logic [5:0] TCCD_LD = 6'(TCCD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSched,
    StPre,
    StWaitRp,
    StAct,
    StWaitRcd,
    StCas
  } state_e;

  state_e r_state;
  state_e w_state_d;

  // Latched request
  logic                 r_we;
  logic [BGWIDTH-1:0]   r_bg;
  logic [BAWIDTH-1:0]   r_ba;
  logic [ADDRWIDTH-1:0] r_row;
  logic [COLWIDTH-1:0]  r_col;
  logic                 r_hit;

  // Bank table and timers
  logic                 r_open     [NBANKS];
  logic [ADDRWIDTH-1:0] r_open_row [NBANKS];
  logic [5:0]           r_ras_cnt  [NBANKS];
  logic [5:0]           r_rp_cnt;
  logic [5:0]           r_rcd_cnt;
  logic [5:0]           r_ccd_cnt;

  // Registered command bus
  logic                 r_cke;
  logic                 r_cs_n;
  logic                 r_act_n;
  logic [ADDRWIDTH-1:0] r_a;
  logic                 r_ready;
  logic                 r_done;
  logic                 r_done_hit;

  logic [BANKW-1:0]     w_bank;
  logic                 w_accept;
  logic                 w_issue_pre;
  logic                 w_issue_act;
  logic                 w_issue_cas;
  logic                 w_hit_d;
  logic                 w_ready_d;
  logic [ADDRWIDTH-1:0] w_a_rd;
  logic [ADDRWIDTH-1:0] w_a_wr;
  logic [ADDRWIDTH-1:0] w_a_pre;

  assign w_bank = {r_bg, r_ba};

  // Command encodings for the latched request; A10 and unused bits stay 0
  always_comb begin
    w_a_rd                 = '0;
    w_a_rd[16:14]          = 3'b101;
    w_a_rd[COLWIDTH-1:0]   = r_col;
    w_a_wr                 = '0;
    w_a_wr[16:14]          = 3'b100;
    w_a_wr[COLWIDTH-1:0]   = r_col;
    w_a_pre                = '0;
    w_a_pre[16:14]         = 3'b010;
  end

  // Next-state and command-issue decisions
  always_comb begin
    w_state_d   = r_state;
    w_accept    = 1'b0;
    w_issue_pre = 1'b0;
    w_issue_act = 1'b0;
    w_issue_cas = 1'b0;
    w_hit_d     = r_hit;
    unique case (r_state)
      StIdle: begin
        if (req_valid && r_ready) begin
          w_accept  = 1'b1;
          w_state_d = StSched;
        end
      end
      StSched: begin
        if (r_open[w_bank] && (r_open_row[w_bank] == r_row)) begin
          w_hit_d = 1'b1;
          // A hit with tCCD expired goes straight onto the bus from here
          if (r_ccd_cnt == 6'd0) begin
            w_issue_cas = 1'b1;
            w_state_d   = StIdle;
          end else begin
            w_state_d = StCas;
          end
        end else if (r_open[w_bank]) begin
          w_hit_d   = 1'b0;
          w_state_d = StPre;
        end else begin
          w_hit_d   = 1'b0;
          w_state_d = StAct;
        end
      end
      StPre: begin
        if (r_ras_cnt[w_bank] == 6'd0) begin
          w_issue_pre = 1'b1;
          w_state_d   = (TRP == 1) ? StAct : StWaitRp;
        end
      end
      StWaitRp: begin
        // Leave one edge early so ACT lands exactly TRP cycles after PRE
        if (r_rp_cnt <= 6'd1) begin
          w_state_d = StAct;
        end
      end
      StAct: begin
        w_issue_act = 1'b1;
        w_state_d   = (TRCD == 1) ? StCas : StWaitRcd;
      end
      StWaitRcd: begin
        if (r_rcd_cnt <= 6'd1) begin
          w_state_d = StCas;
        end
      end
      StCas: begin
        if (r_ccd_cnt == 6'd0) begin
          w_issue_cas = 1'b1;
          w_state_d   = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_ready_d = r_cke && (w_state_d == StIdle);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Request latch on handshake; hit flag captured during classification
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we  <= 1'b0;
      r_bg  <= '0;
      r_ba  <= '0;
      r_row <= '0;
      r_col <= '0;
      r_hit <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we  <= req_we;
        r_bg  <= req_bg;
        r_ba  <= req_ba;
        r_row <= req_row;
        r_col <= req_col;
      end
      r_hit <= w_hit_d;
    end
  end

  // Global timers: load on their command, otherwise count down to 0 and hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rp_cnt  <= '0;
      r_rcd_cnt <= '0;
      r_ccd_cnt <= '0;
    end else begin
      if (w_issue_pre)             r_rp_cnt <= TRP_LD;
      else if (r_rp_cnt != 6'd0)   r_rp_cnt <= r_rp_cnt - 6'd1;
      if (w_issue_act)             r_rcd_cnt <= TRCD_LD;
      else if (r_rcd_cnt != 6'd0)  r_rcd_cnt <= r_rcd_cnt - 6'd1;
      if (w_issue_cas)             r_ccd_cnt <= TCCD_LD;
      else if (r_ccd_cnt != 6'd0)  r_ccd_cnt <= r_ccd_cnt - 6'd1;
    end
  end

  // Per-bank open-row table and tRAS timers, independent of the FSM state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NBANKS; i++) begin
        r_open[i]     <= 1'b0;
        r_open_row[i] <= '0;
        r_ras_cnt[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NBANKS; i++) begin
        if (w_issue_act && (w_bank == BANKW'(i))) begin
          r_ras_cnt[i] <= TRAS_LD;
        end else if (r_ras_cnt[i] != 6'd0) begin
          r_ras_cnt[i] <= r_ras_cnt[i] - 6'd1;
        end
      end
      if (w_issue_pre) begin
        r_open[w_bank] <= 1'b0;
      end
      if (w_issue_act) begin
        r_open[w_bank]     <= 1'b1;
        r_open_row[w_bank] <= r_row;
      end
    end
  end

  // Registered command bus; deselect unless a command issues this edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cke      <= 1'b0;
      r_cs_n     <= 1'b1;
      r_act_n    <= 1'b1;
      r_a        <= '0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_done_hit <= 1'b0;
    end else begin
      r_cke      <= 1'b1;
      r_ready    <= w_ready_d;
      r_cs_n     <= 1'b1;
      r_act_n    <= 1'b1;
      r_a        <= '0;
      r_done     <= 1'b0;
      r_done_hit <= 1'b0;
      if (w_issue_act) begin
        r_cs_n  <= 1'b0;
        r_act_n <= 1'b0;
        r_a     <= r_row;
      end else if (w_issue_pre) begin
        r_cs_n <= 1'b0;
        r_a    <= w_a_pre;
      end else if (w_issue_cas) begin
        r_cs_n     <= 1'b0;
        r_a        <= r_we ? w_a_wr : w_a_rd;
        r_done     <= 1'b1;
        r_done_hit <= w_hit_d;
      end
    end
  end

  assign cke       = r_cke;
  assign cs_n      = r_cs_n;
  assign act_n     = r_act_n;
  assign A         = r_a;
  assign bg        = r_bg;
  assign ba        = r_ba;
  assign req_ready = r_ready;
  assign done      = r_done;
  assign done_hit  = r_done_hit;

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// Bench for ddr4_cmd_issuer: table of requests with hand-classified hit/closed/miss,
// expected command sequences queued at each handshake and checked against the bus,
// plus a mid-sequence asynchronous reset.
module tb_ddr4_cmd_issuer;

  localparam int TRCD = 4;
  localparam int TRP  = 4;
  localparam int TRAS = 16;
  localparam int TCCD = 4;

  localparam int KACT = 0;
  localparam int KPRE = 1;
  localparam int KCAS = 2;
  localparam int KBAD = 3;

  // Request classes in the vector table
  localparam int VHIT    = 0;
  localparam int VCLOSED = 1;
  localparam int VMISS   = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_bg = '0;
  logic [1:0]  req_ba = '0;
  logic [16:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        cke, cs_n, act_n, done, done_hit;
  logic [16:0] A;
  logic [1:0]  bg, ba;

  ddr4_cmd_issuer #(
    .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .COLWIDTH(10),
    .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS), .TCCD(TCCD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .cke(cke), .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
    .done(done), .done_hit(done_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [16:0] row;
    logic [9:0]  col;
    int          kind;
  } vec_t;

  typedef struct {
    int          kind;
    logic [16:0] a;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic        hit;
    bit          after_pre;
    int          acc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  int  n_tests = 0;
  int  n_fail = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  int  last_act[16];
  int  last_pre = -1000;
  int  last_cas = -1000;
  int  n_done_seen = 0;
  int  n_done_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic clear_timing();
    for (int i = 0; i < 16; i++) last_act[i] = -1000;
    last_pre = -1000;
    last_cas = -1000;
  endtask

  task automatic push_expect(input vec_t v, input int acc);
    exp_t e;
    e.bg = v.bg;
    e.ba = v.ba;
    e.acc = acc;
    e.hit = 1'b0;
    e.after_pre = 1'b0;
    if (v.kind == VMISS) begin
      e.kind = KPRE;
      e.a = '0;
      e.a[16:14] = 3'b010;
      sb.push_back(e);
    end
    if (v.kind != VHIT) begin
      e.kind = KACT;
      e.a = v.row;
      e.after_pre = (v.kind == VMISS);
      sb.push_back(e);
    end
    e.kind = KCAS;
    e.after_pre = 1'b0;
    e.hit = (v.kind == VHIT);
    e.a = '0;
    e.a[16:14] = v.we ? 3'b100 : 3'b101;
    e.a[9:0] = v.col;
    sb.push_back(e);
    n_done_exp++;
  endtask

  // Hold valid with junk fields while not ready; present the real request on the edge
  // where ready is known to be high.
  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        req_valid = 1'b1;
        req_we = v.we;
        req_bg = v.bg;
        req_ba = v.ba;
        req_row = v.row;
        req_col = v.col;
        push_expect(v, cyc + 1);
        @(posedge clk);
        ok = 1'b1;
        break;
      end else begin
        req_valid = 1'b1;
        req_we = 1'($urandom);
        req_bg = 2'($urandom);
        req_ba = 2'($urandom);
        req_row = 17'($urandom);
        req_col = 10'($urandom);
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: req_ready never rose within 300 cycles");
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expected commands never appeared", sb.size());
    end
  endtask

  // Bus monitor: pops expected commands and checks encoding and spacing
  initial begin
    exp_t e;
    int   kg;
    int   b;
    int   want;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!cs_n) begin
          if (!act_n)                                     kg = KACT;
          else if (A[16:14] == 3'b010)                    kg = KPRE;
          else if (A[16:14] == 3'b101 || A[16:14] == 3'b100) kg = KCAS;
          else                                            kg = KBAD;
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_cmd: got kind %0d A=0x%0h, want none", kg, A);
          end else begin
            e = sb.pop_front();
            b = int'({bg, ba});
            chk("cmd_kind", kg, e.kind);
            chk("cmd_A", A, e.a);
            chk("cmd_bg", bg, e.bg);
            chk("cmd_ba", ba, e.ba);
            if (e.kind == KACT) begin
              chk("act_done_low", done, 0);
              if (e.after_pre) chk("pre_to_act", cyc - last_pre, TRP);
              last_act[b] = cyc;
            end else if (e.kind == KPRE) begin
              chk("pre_done_low", done, 0);
              chk("act_to_pre_ge_tras", (cyc - last_act[b]) >= TRAS, 1);
              last_pre = cyc;
            end else begin
              chk("cas_done", done, 1);
              chk("cas_done_hit", done_hit, e.hit);
              if (e.hit) want = imax(e.acc + 1, last_cas + TCCD);
              else       want = imax(last_act[b] + TRCD, last_cas + TCCD);
              chk("cas_cycle", cyc, want);
              last_cas = cyc;
            end
          end
        end else if (done) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_without_cmd: got done=1, want 0 at cycle %0d", cyc);
        end
        if (done) n_done_seen++;
      end
    end
  end

  initial begin
    vec_t rv0;
    vec_t rv1;
    bit   seen;

    vecs[0] = '{we: 1'b1, bg: 2'd1, ba: 2'd2, row: 17'h00155, col: 10'h008, kind: VCLOSED};
    vecs[1] = '{we: 1'b0, bg: 2'd1, ba: 2'd2, row: 17'h00155, col: 10'h010, kind: VHIT};
    vecs[2] = '{we: 1'b0, bg: 2'd1, ba: 2'd2, row: 17'h002AA, col: 10'h020, kind: VMISS};
    vecs[3] = '{we: 1'b0, bg: 2'd0, ba: 2'd0, row: 17'h00001, col: 10'h004, kind: VCLOSED};
    vecs[4] = '{we: 1'b1, bg: 2'd1, ba: 2'd2, row: 17'h002AA, col: 10'h3FF, kind: VHIT};
    vecs[5] = '{we: 1'b0, bg: 2'd3, ba: 2'd3, row: 17'h1FFFF, col: 10'h155, kind: VCLOSED};
    vecs[6] = '{we: 1'b1, bg: 2'd3, ba: 2'd3, row: 17'h1FFFF, col: 10'h000, kind: VHIT};
    vecs[7] = '{we: 1'b0, bg: 2'd0, ba: 2'd0, row: 17'h0ABCD, col: 10'h001, kind: VMISS};
    rv0 = '{we: 1'b1, bg: 2'd2, ba: 2'd1, row: 17'h00777, col: 10'h012, kind: VCLOSED};
    rv1 = '{we: 1'b0, bg: 2'd1, ba: 2'd2, row: 17'h002AA, col: 10'h005, kind: VCLOSED};
    clear_timing();

    // Reset values
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cke", cke, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_act_n", act_n, 1);
    chk("rst_A", A, 0);
    chk("rst_bg", bg, 0);
    chk("rst_ba", ba, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_done_hit", done_hit, 0);
    reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("cke_first_edge", cke, 1);
    chk("ready_low_first_edge", req_ready, 0);

    // Table-driven requests, back to back
    for (int i = 0; i < 8; i++) send(vecs[i]);
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    // Asynchronous reset between ACT and WR
    send(rv0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (!cs_n && !act_n) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reset_test_act_seen", seen, 1);
    #2;
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_cs_n", cs_n, 1);
    chk("async_cke", cke, 0);
    chk("async_req_ready", req_ready, 0);
    chk("async_act_n", act_n, 1);
    chk("async_done", done, 0);
    sb.delete();
    n_done_exp--;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_reset_done", done, 0);
      chk("in_reset_cs_n", cs_n, 1);
    end
    #2 reset_n = 1'b1;
    clear_timing();
    mon_en = 1'b1;
    send(rv0);
    send(rv1);
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("done_per_handshake", n_done_seen, n_done_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
